vector_loader: RTL and testbench

VECTOR_LOADER -- requirements
Module: vector_loader

---
 rtl/coproc_pkg.sv | 24 ++
 rtl/index_counter.sv | 40 ++++
 rtl/vector_loader.sv | 178 +++++++++++++++++
 tb/tb_vector_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - shared loader state encoding and default vector geometry (VECTOR_LOADER_CHECKSUM_EN adds CHECK)
package coproc_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LENGTH = 512;

`ifdef VECTOR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_CHECK,
        ST_DONE
    } loader_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_DONE
    } loader_state_t;
`endif

endpackage

// File: rtl/index_counter.sv
// rtl/index_counter.sv - element index with clear, enable, wrap at LENGTH-1 and terminal-count flag
module index_counter #(
    parameter int LENGTH = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    output logic [$clog2(LENGTH)-1:0] count,
    output logic                      tc
);

    localparam int IDX_W = $clog2(LENGTH);

    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;

    assign tc    = (count_q == IDX_W'(LENGTH - 1));
    assign count = count_q;

    // clear wins over enable; the last element wraps back to 0
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    // index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vector_loader.sv
// rtl/vector_loader.sv - streams two vectors into register arrays; VECTOR_LOADER_CHECKSUM_EN adds a trailing checksum beat
module vector_loader
    import coproc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] array_a [LENGTH],
    output logic [WIDTH-1:0] array_b [LENGTH],
    output logic             arrays_valid,
    input  logic             consume,
    output logic             chk_err
);

    localparam int IDX_W = $clog2(LENGTH);

    loader_state_t    state_q, state_d;
    logic [WIDTH-1:0] array_a_q [LENGTH];
    logic [WIDTH-1:0] array_a_d [LENGTH];
    logic [WIDTH-1:0] array_b_q [LENGTH];
    logic [WIDTH-1:0] array_b_d [LENGTH];
    logic [IDX_W-1:0] idx;
    logic             idx_tc;
    logic             idx_clear;
    logic             wr_a;
    logic             wr_b;

`ifdef VECTOR_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             chk_err_q, chk_err_d;
`endif

    index_counter #(.LENGTH(LENGTH)) u_index (
        .clk    (clk),
        .rst    (rst),
        .clear  (idx_clear),
        .enable (wr_a | wr_b),
        .count  (idx),
        .tc     (idx_tc)
    );

    // next state, handshake and write strobes; abort overrides everything last
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        idx_clear = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
`ifdef VECTOR_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD_A;
                    idx_clear = 1'b1;
`ifdef VECTOR_LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    chk_err_d = 1'b0;
`endif
                end
            end
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_a = 1'b1;
`ifdef VECTOR_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                    if (idx_tc) begin
                        state_d = ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_b = 1'b1;
`ifdef VECTOR_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
                    if (idx_tc) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (idx_tc) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef VECTOR_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_IDLE;
                        chk_err_d = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                if (consume) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            idx_clear = 1'b1;
            wr_a      = 1'b0;
            wr_b      = 1'b0;
`ifdef VECTOR_LOADER_CHECKSUM_EN
            chk_err_d = chk_err_q;
`endif
        end
    end

    // array element update for the beat accepted this cycle
    always_comb begin
        array_a_d = array_a_q;
        array_b_d = array_b_q;
        if (wr_a) begin
            array_a_d[idx] = in_data;
        end
        if (wr_b) begin
            array_b_d[idx] = in_data;
        end
    end

    // state and vector registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < LENGTH; i++) begin
                array_a_q[i] <= '0;
                array_b_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            array_a_q <= array_a_d;
            array_b_q <= array_b_d;
        end
    end

`ifdef VECTOR_LOADER_CHECKSUM_EN
    // running checksum and sticky mismatch flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign array_a      = array_a_q;
    assign array_b      = array_b_q;
    assign arrays_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_vector_loader.sv
// tb/tb_vector_loader.sv - directed self-checking bench for vector_loader (WIDTH=8, LENGTH=4)
module tb_vector_loader;

    localparam int W = 8;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] array_a [L];
    logic [W-1:0] array_b [L];
    logic         arrays_valid;
    logic         consume;
    logic         chk_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_q[$];

    vector_loader #(.WIDTH(W), .LENGTH(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .array_a      (array_a),
        .array_b      (array_b),
        .arrays_valid (arrays_valid),
        .consume      (consume),
        .chk_err      (chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic pulse_consume;
        consume = 1'b1;
        tick;
        consume = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit gap);
        in_data  = d;
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: in_ready=%b required 1 for beat %0d", in_ready, d);
        end
        acc_q.push_back(cyc);
        tick;
        in_valid = 1'b0;
        if (gap) tick;
    endtask

    task automatic load_all(input logic [W-1:0] v [8], input bit gap);
        logic [W-1:0] sum;
        int           nb;
        sum = '0;
        for (int i = 0; i < 8; i++) sum = sum + v[i];
        nb = 8;
`ifdef VECTOR_LOADER_CHECKSUM_EN
        nb = 9;
`endif
        for (int k = 0; k < nb; k++) begin
            if (k == nb - 1) begin
                n_cmp++;
                if (arrays_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL valid_early: arrays_valid=%b required 0 before final beat", arrays_valid);
                end
            end
            if (k < 8) send(v[k], gap && (k != nb - 1));
            else       send(sum, 1'b0);
        end
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({in_ready, arrays_valid, chk_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outs: ready/valid/err=%b required 000", {in_ready, arrays_valid, chk_err});
        end
        for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (array_a[i] !== 8'd0 || array_b[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_arrays[%0d]: a=%0d b=%0d required 0", i, array_a[i], array_b[i]);
            end
        end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        pulse_start;
        load_all(v, 1'b0);
        n_cmp++;
        if (arrays_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done: valid=%b ready=%b required 1 0", arrays_valid, in_ready);
        end
        for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (array_a[i] !== 8'(i + 1) || array_b[i] !== 8'(i + 5)) begin
                n_bad++;
                $display("FAIL b2b_arrays[%0d]: a=%0d b=%0d required %0d %0d", i, array_a[i], array_b[i], i + 1, i + 5);
            end
        end
    endtask

    task automatic test_consume;
        logic [W-1:0] v [8];
        in_data  = 8'd99;
        in_valid = 1'b1;
        tick;
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if (array_a[0] !== 8'd1 || array_b[3] !== 8'd8 || arrays_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL done_frozen: a0=%0d b3=%0d valid=%b required 1 8 1", array_a[0], array_b[3], arrays_valid);
        end
        pulse_consume;
        n_cmp++;
        if (arrays_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL consume_idle: valid=%b ready=%b required 0 0", arrays_valid, in_ready);
        end
        n_cmp++;
        if (array_a[2] !== 8'd3 || array_b[1] !== 8'd6) begin
            n_bad++;
            $display("FAIL consume_hold: a2=%0d b1=%0d required 3 6", array_a[2], array_b[1]);
        end
        // start mid-LOAD_A must not restart the index
        pulse_start;
        send(8'd10, 1'b0);
        send(8'd11, 1'b0);
        pulse_start;
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 10);
        for (int k = 2; k < 8; k++) send(v[k], 1'b0);
`ifdef VECTOR_LOADER_CHECKSUM_EN
        send(8'd108, 1'b0);
`endif
        for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (array_a[i] !== 8'(i + 10) || array_b[i] !== 8'(i + 14)) begin
                n_bad++;
                $display("FAIL start_ignored[%0d]: a=%0d b=%0d required %0d %0d", i, array_a[i], array_b[i], i + 10, i + 14);
            end
        end
        n_cmp++;
        if (arrays_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ignored_valid: arrays_valid=%b required 1", arrays_valid);
        end
        pulse_consume;
    endtask

    task automatic test_gaps;
        logic [W-1:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        pulse_start;
        acc_q.delete();
        load_all(v, 1'b1);
        // eight beats, one every other cycle: first to eighth accept is 14 edges apart
        n_cmp++;
        if (acc_q[7] - acc_q[0] !== 14) begin
            n_bad++;
            $display("FAIL gap_timing: accept span=%0d required 14", acc_q[7] - acc_q[0]);
        end
        for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (array_a[i] !== 8'(i + 1) || array_b[i] !== 8'(i + 5)) begin
                n_bad++;
                $display("FAIL gap_arrays[%0d]: a=%0d b=%0d required %0d %0d", i, array_a[i], array_b[i], i + 1, i + 5);
            end
        end
        n_cmp++;
        if (arrays_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_valid: arrays_valid=%b required 1", arrays_valid);
        end
        pulse_consume;
    endtask

    task automatic test_abort;
        logic [W-1:0] v [8];
        pulse_start;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        tick;
        abort    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || arrays_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: ready=%b valid=%b required 0 0", in_ready, arrays_valid);
        end
        n_cmp++;
        if (array_a[3] !== 8'd4) begin
            n_bad++;
            $display("FAIL abort_beat_dropped: a3=%0d required 4", array_a[3]);
        end
        // abort beats a simultaneous start
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_over_start: in_ready=%b required 0", in_ready);
        end
        for (int i = 0; i < 8; i++) v[i] = 8'd9;
        pulse_start;
        load_all(v, 1'b0);
        for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (array_a[i] !== 8'd9 || array_b[i] !== 8'd9) begin
                n_bad++;
                $display("FAIL abort_reload[%0d]: a=%0d b=%0d required 9 9", i, array_a[i], array_b[i]);
            end
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++;
        if (arrays_valid !== 1'b0 || array_b[0] !== 8'd9) begin
            n_bad++;
            $display("FAIL abort_done: valid=%b b0=%0d required 0 9", arrays_valid, array_b[0]);
        end
    endtask

    task automatic test_checksum;
        logic [W-1:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
`ifdef VECTOR_LOADER_CHECKSUM_EN
        pulse_start;
        for (int k = 0; k < 8; k++) send(v[k], 1'b0);
        send(8'd35, 1'b0);
        tick;
        n_cmp++;
        if (chk_err !== 1'b1 || arrays_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_bad: err=%b valid=%b ready=%b required 1 0 0", chk_err, arrays_valid, in_ready);
        end
        pulse_start;
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_clear_on_start: chk_err=%b required 0", chk_err);
        end
        load_all(v, 1'b0);
`else
        pulse_start;
        load_all(v, 1'b0);
`endif
        n_cmp++;
        if (chk_err !== 1'b0 || arrays_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL chk_good: err=%b valid=%b required 0 1", chk_err, arrays_valid);
        end
        pulse_consume;
    endtask

    task automatic test_reset_mid;
        pulse_start;
        for (int k = 0; k < 6; k++) send(8'(k + 21), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, arrays_valid, chk_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_mid_outs: ready/valid/err=%b required 000", {in_ready, arrays_valid, chk_err});
        end
        for (int i = 0; i < L; i++) begin
            n_cmp++;
            if (array_a[i] !== 8'd0 || array_b[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL rst_mid_arrays[%0d]: a=%0d b=%0d required 0", i, array_a[i], array_b[i]);
            end
        end
        tick;
        rst      = 1'b0;
        in_data  = 8'd55;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL no_start_ready: in_ready=%b required 0", in_ready);
            end
            tick;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (array_a[0] !== 8'd0 || arrays_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_start_write: a0=%0d valid=%b required 0 0", array_a[0], arrays_valid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        consume  = 1'b0;
        test_reset;
        test_back_to_back;
        test_consume;
        test_gaps;
        test_abort;
        test_checksum;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
